// File: rtl/decimal_to_bit_packer.sv
`default_nettype none
// ============================================================================
//  Module      : decimal_to_bit_packer
//  Description : Compresses expanded 8-bit coefficients (data on even bits)
//                to 4-bit nibbles and packs four per 16-bit output word.
//  Revision    : 1.0 - initial release
// ============================================================================
module decimal_to_bit_packer #(
    parameter int CHECK_ODD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_coeff,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_word,
    output logic        out_last,
    output logic        err,
    input  logic        clear_err
);

    localparam logic [7:0] c_ODD_MASK  = 8'hAA;
    localparam logic [1:0] c_LAST_SLOT = 2'd3;

    logic [1:0]  r_slot;
    logic [11:0] r_acc;
    logic [15:0] r_out_word;
    logic        r_out_valid;
    logic        r_out_last;
    logic        r_err;

    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_complete;
    logic [3:0]  w_nibble;
    logic [11:0] w_acc_next;
    logic [15:0] w_word;

    assign in_ready   = !(r_out_valid && !out_ready);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_complete = w_in_fire && ((r_slot == c_LAST_SLOT) || in_last);
    assign w_nibble   = {in_coeff[6], in_coeff[4], in_coeff[2], in_coeff[0]};

    // Slots above the current one are always zero because the accumulator
    // is cleared whenever a word completes.
    always_comb begin
        w_acc_next = r_acc;
        w_word     = {4'b0000, r_acc};
        case (r_slot)
            2'd0: begin
                w_acc_next = {r_acc[11:4], w_nibble};
                w_word     = {12'h000, w_nibble};
            end
            2'd1: begin
                w_acc_next = {r_acc[11:8], w_nibble, r_acc[3:0]};
                w_word     = {8'h00, w_nibble, r_acc[3:0]};
            end
            2'd2: begin
                w_acc_next = {w_nibble, r_acc[7:0]};
                w_word     = {4'h0, w_nibble, r_acc[7:0]};
            end
            default: begin
                w_acc_next = r_acc;
                w_word     = {w_nibble, r_acc};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot      <= 2'd0;
            r_acc       <= 12'h000;
            r_out_word  <= 16'h0000;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_complete) begin
            // A completing input may coincide with an output transfer; the
            // new word replaces the old one with no bubble.
            r_out_word  <= w_word;
            r_out_valid <= 1'b1;
            r_out_last  <= in_last;
            r_slot      <= 2'd0;
            r_acc       <= 12'h000;
        end else begin
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_in_fire) begin
                r_acc  <= w_acc_next;
                r_slot <= r_slot + 2'd1;
            end
        end
    end

    generate
        if (CHECK_ODD != 0) begin : g_err_check
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_err <= 1'b0;
                end else if (w_in_fire && ((in_coeff & c_ODD_MASK) != 8'h00)) begin
                    r_err <= 1'b1;
                end else if (clear_err) begin
                    r_err <= 1'b0;
                end
            end
        end else begin : g_err_off
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_err <= 1'b0;
                end else begin
                    r_err <= 1'b0;
                end
            end
        end
    endgenerate

    assign out_word  = r_out_word;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign err       = r_err;

endmodule
`default_nettype wire
